// File: rtl/mipsfpga_ahb_micros_alarm.sv
// mipsfpga_ahb_micros_alarm
//
// AHB-Lite slave that exposes the free-running microseconds count to the CPU
// and adds a compare/alarm unit: a COMPARE register, an optional periodic
// reload by PERIOD, sticky MATCH/OVERRUN status and a level interrupt.
//
// Register map (HADDR[4:2]):
//   0 COUNT   RO   current micros
//   1 COMPARE RW
//   2 CTRL    RW   bit0 EN, bit1 IE, bit2 PERIODIC
//   3 STATUS  W1C  bit0 MATCH, bit1 OVERRUN
//   4 PERIOD  RW
//   5-7       read 0, writes ignored
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   micros               free-running 32-bit microseconds count (clk domain)
//   HSEL/HADDR/HTRANS/HWRITE/HREADY/HWDATA   AHB-Lite slave inputs
//   HRDATA/HREADYOUT/HRESP                   AHB-Lite slave outputs
//   irq                  level interrupt, MATCH & IE, driven from a flop
module mipsfpga_ahb_micros_alarm #(
    parameter logic [31:0] RELOAD_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] micros,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic        irq
);

    localparam int DATA_W = 32;

    localparam logic [2:0] A_COUNT   = 3'd0;
    localparam logic [2:0] A_COMPARE = 3'd1;
    localparam logic [2:0] A_CTRL    = 3'd2;
    localparam logic [2:0] A_STATUS  = 3'd3;
    localparam logic [2:0] A_PERIOD  = 3'd4;

    // Modulo-2^32 addition; the alarm schedule is allowed to wrap.
    function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        return a + b;
    endfunction

    // Address-phase capture
    logic [2:0]        addr_p1;
    logic              write_p1;
    logic              vld_p1;

    // Alarm state
    logic [DATA_W-1:0] micros_q;
    logic [DATA_W-1:0] compare;
    logic [DATA_W-1:0] period;
    logic              ctrl_en;
    logic              ctrl_ie;
    logic              ctrl_per;
    logic              sts_match;
    logic              sts_overrun;

    logic [DATA_W-1:0] compare_nxt;
    logic              match_nxt;
    logic              overrun_nxt;
    logic              ie_nxt;
    logic              match_evt;
    logic              wr_compare;
    logic              wr_ctrl;
    logic              wr_status;
    logic              wr_period;

    logic              unused_bits;
    assign unused_bits = ^{HADDR[31:5], HADDR[1:0], HTRANS[0]};

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

    // Stage p0 -> p1: address phase latches the transfer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_p1  <= 3'd0;
            write_p1 <= 1'b0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= HSEL & HTRANS[1] & HREADY;
            if (HSEL & HTRANS[1] & HREADY) begin
                addr_p1  <= HADDR[4:2];
                write_p1 <= HWRITE;
            end
        end
    end

    // Data phase: write decode, match detection and next-state
    always_comb begin
        wr_compare = vld_p1 & write_p1 & (addr_p1 == A_COMPARE);
        wr_ctrl    = vld_p1 & write_p1 & (addr_p1 == A_CTRL);
        wr_status  = vld_p1 & write_p1 & (addr_p1 == A_STATUS);
        wr_period  = vld_p1 & write_p1 & (addr_p1 == A_PERIOD);

        // Only a count that newly arrives at COMPARE fires; a held count or a
        // COMPARE write equal to the present count does not.
        match_evt = ctrl_en & (micros == compare) & (micros != micros_q);

        // A new match beats a simultaneous W1C of MATCH, and then it is not
        // an overrun because software has just serviced the previous one.
        match_nxt   = match_evt | (sts_match & ~(wr_status & HWDATA[0]));
        overrun_nxt = (match_evt & sts_match & ~(wr_status & HWDATA[0]))
                    | (sts_overrun & ~(wr_status & HWDATA[1]));

        // CPU write to COMPARE takes priority over the periodic reload.
        compare_nxt = compare;
        if (wr_compare)
            compare_nxt = HWDATA;
        else if (match_evt & ctrl_per)
            compare_nxt = wrap_add(compare, period);

        ie_nxt = wr_ctrl ? HWDATA[1] : ctrl_ie;
    end

    // Stage p1 -> p2: register update
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            micros_q    <= '0;
            compare     <= '0;
            period      <= RELOAD_RESET;
            ctrl_en     <= 1'b0;
            ctrl_ie     <= 1'b0;
            ctrl_per    <= 1'b0;
            sts_match   <= 1'b0;
            sts_overrun <= 1'b0;
            irq         <= 1'b0;
        end else begin
            micros_q    <= micros;
            compare     <= compare_nxt;
            sts_match   <= match_nxt;
            sts_overrun <= overrun_nxt;
            irq         <= match_nxt & ie_nxt;
            if (wr_period)
                period <= HWDATA;
            if (wr_ctrl) begin
                ctrl_en  <= HWDATA[0];
                ctrl_ie  <= HWDATA[1];
                ctrl_per <= HWDATA[2];
            end
        end
    end

    // Read mux: combinational from the latched address and live state
    always_comb begin
        HRDATA = '0;
        if (vld_p1 & ~write_p1) begin
            case (addr_p1)
                A_COUNT:   HRDATA = micros;
                A_COMPARE: HRDATA = compare;
                A_CTRL:    HRDATA = {29'd0, ctrl_per, ctrl_ie, ctrl_en};
                A_STATUS:  HRDATA = {30'd0, sts_overrun, sts_match};
                A_PERIOD:  HRDATA = period;
                default:   HRDATA = '0;
            endcase
        end
    end

endmodule
